// File: rtl/vga_spectrum_renderer.sv
// VGA timing generator and N-bar spectrum renderer on a single pixel clock.
// Bin magnitudes go into a staging bank. A commit arms a copy into the active
// bank, and that copy happens on the first vblank line. Each bar has a
// peak-hold marker that decays once per frame. The vertical colour gradient
// has three zones. Pixel outputs come two clocks after the scan counters.
module vga_spectrum_renderer #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int NUM_BARS    = 16,
    parameter int BAR_GAP     = 2,
    parameter int DATA_W      = 24,
    parameter int SCALE_SHIFT = 6,
    parameter int PEAK_DECAY  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        bin_valid,
    input  logic [$clog2(NUM_BARS)-1:0] bin_idx,
    input  logic [DATA_W-1:0]           bin_data,
    input  logic                        bin_commit,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        de,
    output logic [3:0]                  r,
    output logic [3:0]                  g,
    output logic [3:0]                  b,
    output logic                        frame_update
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int BAR_W   = H_DISPLAY / NUM_BARS;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int YW      = $clog2(V_DISPLAY + 1);
    localparam int IW      = $clog2(NUM_BARS);
    localparam int BXW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    // Convert a signed magnitude into a bar height. A negative value gives
    // height 0. A positive value is scaled down and clamped to the screen height.
    function automatic logic [YW-1:0] mag_to_height(input logic [DATA_W-1:0] mag);
        logic [DATA_W-1:0] shifted;
        shifted = mag >> SCALE_SHIFT;
        if (mag[DATA_W-1]) begin
            mag_to_height = {YW{1'b0}};
        end else if (shifted > DATA_W'(V_DISPLAY)) begin
            mag_to_height = YW'(V_DISPLAY);
        end else begin
            mag_to_height = shifted[YW-1:0];
        end
    endfunction

    // Scan state
    logic [HW-1:0]  hcount_r;
    logic [VW-1:0]  vcount_r;
    logic [BXW-1:0] bar_x_r;
    logic [IW-1:0]  bar_idx_r;
    logic           h_last_s;
    logic           v_last_s;
    logic           hsync_raw_s;
    logic           vsync_raw_s;
    logic           de_raw_s;
    logic           update_s;

    // Bar banks
    logic [YW-1:0]  staging_r    [NUM_BARS];
    logic [YW-1:0]  active_r     [NUM_BARS];
    logic [YW-1:0]  peak_r       [NUM_BARS];
    logic [YW-1:0]  new_active_s [NUM_BARS];
    logic [YW-1:0]  peak_next_s  [NUM_BARS];
    logic [YW-1:0]  wr_height_s;
    logic           commit_pending_r;

    // Pipeline stage 1
    logic [YW-1:0]  s1_height_r;
    logic [YW-1:0]  s1_peak_r;
    logic           s1_gap_r;
    logic [VW-1:0]  s1_y_r;
    logic           s1_de_r;
    logic           s1_hsync_r;
    logic           s1_vsync_r;
    logic [11:0]    color_s;

    // Decode wrap points, the raw sync/blank windows and the frame-update cycle
    always_comb begin
        h_last_s    = (hcount_r == HW'(H_TOTAL - 1));
        v_last_s    = (vcount_r == VW'(V_TOTAL - 1));
        hsync_raw_s = !((hcount_r >= HW'(H_DISPLAY + H_FRONT)) &&
                        (hcount_r <  HW'(H_DISPLAY + H_FRONT + H_SYNC)));
        vsync_raw_s = !((vcount_r >= VW'(V_DISPLAY + V_FRONT)) &&
                        (vcount_r <  VW'(V_DISPLAY + V_FRONT + V_SYNC)));
        de_raw_s    = (hcount_r < HW'(H_DISPLAY)) && (vcount_r < VW'(V_DISPLAY));
        update_s    = (hcount_r == {HW{1'b0}}) && (vcount_r == VW'(V_DISPLAY));
        wr_height_s = mag_to_height(bin_data);
    end

    // Pixel/line counters plus column trackers, so no divider is needed to find the bar
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_r  <= {HW{1'b0}};
            vcount_r  <= {VW{1'b0}};
            bar_x_r   <= {BXW{1'b0}};
            bar_idx_r <= {IW{1'b0}};
        end else if (h_last_s) begin
            hcount_r  <= {HW{1'b0}};
            bar_x_r   <= {BXW{1'b0}};
            bar_idx_r <= {IW{1'b0}};
            vcount_r  <= v_last_s ? {VW{1'b0}} : vcount_r + VW'(1);
        end else begin
            hcount_r <= hcount_r + HW'(1);
            if (bar_x_r == BXW'(BAR_W - 1)) begin
                bar_x_r <= {BXW{1'b0}};
                // Stop on the last bar so that blanking columns never index past the bank
                if (bar_idx_r != IW'(NUM_BARS - 1)) begin
                    bar_idx_r <= bar_idx_r + IW'(1);
                end
            end else begin
                bar_x_r <= bar_x_r + BXW'(1);
            end
        end
    end

    // Compute each bar's post-copy height and its peak-hold value for the update cycle
    always_comb begin
        for (int i = 0; i < NUM_BARS; i++) begin
            new_active_s[i] = active_r[i];
            peak_next_s[i]  = {YW{1'b0}};
            if (update_s && commit_pending_r) begin
                new_active_s[i] = staging_r[i];
            end else begin
                new_active_s[i] = active_r[i];
            end
            if (peak_r[i] > YW'(PEAK_DECAY)) begin
                peak_next_s[i] = peak_r[i] - YW'(PEAK_DECAY);
            end else begin
                peak_next_s[i] = {YW{1'b0}};
            end
            if (new_active_s[i] > peak_next_s[i]) begin
                peak_next_s[i] = new_active_s[i];
            end else begin
                peak_next_s[i] = peak_next_s[i];
            end
        end
    end

    // Staging writes, the commit flag, the active-bank copy and the per-frame peak decay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                staging_r[i] <= {YW{1'b0}};
                active_r[i]  <= {YW{1'b0}};
                peak_r[i]    <= {YW{1'b0}};
            end
            commit_pending_r <= 1'b0;
            frame_update     <= 1'b0;
        end else begin
            // A write on the update cycle lands after the copy because of NBA ordering
            for (int i = 0; i < NUM_BARS; i++) begin
                if (bin_valid && (bin_idx == IW'(i))) begin
                    staging_r[i] <= wr_height_s;
                end
                if (update_s) begin
                    active_r[i] <= new_active_s[i];
                    peak_r[i]   <= peak_next_s[i];
                end
            end
            if (bin_commit) begin
                commit_pending_r <= 1'b1;
            end else if (update_s) begin
                commit_pending_r <= 1'b0;
            end
            frame_update <= update_s;
        end
    end

    // Stage 1: latch the current bar's height, its peak and the gap flag with the row and sync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_height_r <= {YW{1'b0}};
            s1_peak_r   <= {YW{1'b0}};
            s1_gap_r    <= 1'b0;
            s1_y_r      <= {VW{1'b0}};
            s1_de_r     <= 1'b0;
            s1_hsync_r  <= 1'b1;
            s1_vsync_r  <= 1'b1;
        end else begin
            s1_height_r <= active_r[bar_idx_r];
            s1_peak_r   <= peak_r[bar_idx_r];
            s1_gap_r    <= ({1'b0, bar_x_r} >= (BXW + 1)'(BAR_W - BAR_GAP));
            s1_y_r      <= vcount_r;
            s1_de_r     <= de_raw_s;
            s1_hsync_r  <= hsync_raw_s;
            s1_vsync_r  <= vsync_raw_s;
        end
    end

    // Stage 2 colour: blank, then gap, then peak marker, then the lit gradient zone
    always_comb begin
        color_s = 12'h000;
        if (!s1_de_r) begin
            color_s = 12'h000;
        end else if (s1_gap_r) begin
            color_s = 12'h000;
        end else if ((s1_peak_r != {YW{1'b0}}) &&
                     (s1_y_r == VW'(V_DISPLAY) - VW'(s1_peak_r))) begin
            color_s = 12'hFFF;
        end else if (s1_y_r >= VW'(V_DISPLAY) - VW'(s1_height_r)) begin
            if (s1_y_r < VW'(V_DISPLAY / 3)) begin
                color_s = 12'hF00;
            end else if (s1_y_r < VW'((2 * V_DISPLAY) / 3)) begin
                color_s = 12'hFF0;
            end else begin
                color_s = 12'h0F0;
            end
        end else begin
            color_s = 12'h000;
        end
    end

    // Stage 2 registers: drive the connector with colour and delayed sync/blank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
            r     <= 4'h0;
            g     <= 4'h0;
            b     <= 4'h0;
        end else begin
            hsync <= s1_hsync_r;
            vsync <= s1_vsync_r;
            de    <= s1_de_r;
            r     <= color_s[11:8];
            g     <= color_s[7:4];
            b     <= color_s[3:0];
        end
    end

endmodule

// File: tb/tb_vga_spectrum_renderer.sv
// Self-checking bench for vga_spectrum_renderer with a reduced screen geometry.
// A behavioural model finds the scan position from a cycle count. It keeps the
// bar banks as integer arrays and predicts the pixel, sync and frame-update
// outputs. The outputs are compared two clocks later.
module tb_vga_spectrum_renderer;

    localparam int HD  = 32;
    localparam int HF  = 4;
    localparam int HSY = 6;
    localparam int HB  = 6;
    localparam int VD  = 24;
    localparam int VF  = 2;
    localparam int VSY = 2;
    localparam int VB  = 3;
    localparam int NB  = 4;
    localparam int GAP = 2;
    localparam int DW  = 12;
    localparam int SS  = 2;
    localparam int DEC = 3;
    localparam int HT  = HD + HF + HSY + HB;
    localparam int VT  = VD + VF + VSY + VB;
    localparam int BW  = HD / NB;
    localparam int IW  = $clog2(NB);
    localparam int SEQ_N = 18;
    localparam logic [14:0] RST_VEC = 15'b110_0000_0000_0000;

    logic          clk;
    logic          rst_n;
    logic          bin_valid;
    logic [IW-1:0] bin_idx;
    logic [DW-1:0] bin_data;
    logic          bin_commit;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [3:0]    r;
    logic [3:0]    g;
    logic [3:0]    b;
    logic          frame_update;

    vga_spectrum_renderer #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .NUM_BARS(NB), .BAR_GAP(GAP), .DATA_W(DW), .SCALE_SHIFT(SS),
        .PEAK_DECAY(DEC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bin_valid(bin_valid), .bin_idx(bin_idx),
        .bin_data(bin_data), .bin_commit(bin_commit), .hsync(hsync),
        .vsync(vsync), .de(de), .r(r), .g(g), .b(b), .frame_update(frame_update)
    );

    // Pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_staging [NB];
    int          m_active  [NB];
    int          m_peak    [NB];
    bit          m_pending;
    bit          fu_exp;
    int          k;
    int          policy;
    int          frame_no;
    bit          post_rst;
    int          seq [SEQ_N];
    logic [14:0] pipe_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    function automatic int model_height(input logic [DW-1:0] d);
        int unsigned mag;
        mag = d;
        if (d[DW-1]) return 0;
        if (mag / (1 << SS) > VD) return VD;
        return int'(mag / (1 << SS));
    endfunction

    function automatic logic [14:0] pix_model(input int h, input int v);
        logic hs, vs, den;
        logic [11:0] c;
        int bar, bx;
        hs  = !((h >= HD + HF) && (h < HD + HF + HSY));
        vs  = !((v >= VD + VF) && (v < VD + VF + VSY));
        den = (h < HD) && (v < VD);
        c   = 12'h000;
        if (den) begin
            bar = h / BW;
            bx  = h % BW;
            if (bx < BW - GAP) begin
                if (m_peak[bar] > 0 && v == VD - m_peak[bar]) c = 12'hFFF;
                else if (v >= VD - m_active[bar]) begin
                    if (v < VD / 3) c = 12'hF00;
                    else if (v < 2 * VD / 3) c = 12'hFF0;
                    else c = 12'h0F0;
                end
            end
        end
        return {hs, vs, den, c};
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        d = DW'($urandom);
        case ($urandom_range(0, 3))
            0: d[DW-1] = 1'b1;
            1: d[DW-1] = 1'b0;
            2: d = DW'($urandom_range(0, VD * (1 << SS) + (1 << SS)));
            default: d = DW'(VD * (1 << SS) + $urandom_range(0, 4));
        endcase
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_staging[i] = 0;
            m_active[i]  = 0;
            m_peak[i]    = 0;
        end
        m_pending = 1'b0;
        fu_exp    = 1'b0;
        k         = 0;
        pipe_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_sync"}, 32'({hsync, vsync, de}), 32'(RST_VEC[14:12]));
        check_eq({tag, "_rgb"}, 32'({r, g, b}), 32'h0);
        check_eq({tag, "_fupd"}, 32'(frame_update), 32'h0);
    endtask

    // One clock interval: compare outputs, drive the inputs, then advance the model
    task automatic cycle_body();
        int h, v;
        bit upd;
        logic [14:0] exp_out;
        h = k % HT;
        v = (k / HT) % VT;
        pipe_q.push_back(pix_model(h, v));
        if (pipe_q.size() > 2) exp_out = pipe_q.pop_front();
        else exp_out = RST_VEC;
        check_eq("sync", 32'({hsync, vsync, de}), 32'(exp_out[14:12]));
        check_eq("rgb", 32'({r, g, b}), 32'(exp_out[11:0]));
        check_eq("fupd", 32'(frame_update), 32'(fu_exp));

        if (h == 0 && v == 0) begin
            if (!post_rst && frame_no < SEQ_N) policy = seq[frame_no];
            else policy = $urandom_range(0, 3);
            frame_no++;
        end

        bin_valid  = 1'b0;
        bin_commit = 1'b0;
        bin_idx    = '0;
        bin_data   = '0;
        case (policy)
            0: begin
                if ($urandom_range(0, 31) == 0) begin
                    bin_valid = 1'b1; bin_idx = IW'($urandom); bin_data = rand_data();
                end
                if ($urandom_range(0, 999) == 0) bin_commit = 1'b1;
            end
            1: begin
                if ($urandom_range(0, 31) == 0) begin
                    bin_valid = 1'b1; bin_idx = IW'($urandom); bin_data = rand_data();
                end
            end
            3: begin
                if (h == 0 && v == VD) begin
                    bin_valid = 1'b1; bin_idx = IW'($urandom); bin_data = rand_data();
                    bin_commit = 1'b1;
                end else if ($urandom_range(0, 63) == 0) begin
                    bin_valid = 1'b1; bin_idx = IW'($urandom); bin_data = rand_data();
                end
            end
            4, 5: begin
                if (v == 1 && h < NB) begin
                    bin_valid = 1'b1; bin_idx = IW'(h);
                    bin_data = (policy == 4) ? DW'(12'h7FF) : DW'(12'h000);
                end else if (v == 1 && h == NB) begin
                    bin_commit = 1'b1;
                end
            end
            default: ;
        endcase

        upd = (h == 0 && v == VD);
        if (upd) begin
            for (int i = 0; i < NB; i++) begin
                int pk;
                if (m_pending) m_active[i] = m_staging[i];
                pk = m_peak[i] - DEC;
                if (pk < 0) pk = 0;
                m_peak[i] = (m_active[i] > pk) ? m_active[i] : pk;
            end
        end
        if (bin_commit) m_pending = 1'b1;
        else if (upd) m_pending = 1'b0;
        if (bin_valid && int'(bin_idx) < NB) m_staging[bin_idx] = model_height(bin_data);
        fu_exp = upd;
        k++;
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cycle_body();
        end
    endtask

    // Stimulus and checking sequence
    initial begin
        seq = '{4, 5, 5, 5, 5, 5, 5, 5, 5, 5, 2, 0, 1, 1, 3, 0, 3, 0};
        rst_n      = 1'b0;
        bin_valid  = 1'b0;
        bin_idx    = '0;
        bin_data   = '0;
        bin_commit = 1'b0;
        policy     = 2;
        frame_no   = 0;
        post_rst   = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        cycle_body();
        step(SEQ_N * HT * VT + 10 * HT + 20 - 1);

        // Reset in the middle of a visible line, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        bin_valid  = 1'b0;
        bin_commit = 1'b0;
        model_reset();
        post_rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        cycle_body();
        step(4 * HT * VT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_spectrum_renderer.md
Name: vga_spectrum_renderer

Overview:
Parametrised successor to the 640x480 sync generator and bar-display pair. It merges H/V timing generation and N-bar spectrum rendering into one single-clock block. Bin magnitudes are written into a staging bank through an indexed write port and take effect only on a frame boundary. Rendering adds per-bar peak-hold markers with per-frame decay and a three-zone vertical colour gradient. The block drives the VGA connector directly and replaces the free-running counters with correct full-period wrap.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
NUM_BARS, 16, bar count; H_DISPLAY must be divisible by NUM_BARS
BAR_GAP, 2, black pixels at the right edge of each bar; must be less than BAR_W = H_DISPLAY/NUM_BARS
DATA_W, 24, bin magnitude width, two's complement
SCALE_SHIFT, 6, height = magnitude >> SCALE_SHIFT
PEAK_DECAY, 4, peak marker fall per frame (rows)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
bin_valid  in  1  write strobe for staging bank
bin_idx  in  $clog2(NUM_BARS)  bar index written
bin_data  in  DATA_W  signed bin magnitude
bin_commit  in  1  marks staging bank complete; arms the next frame update
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
de  out  1  high in the visible region
r, g, b  out  4 each  pixel colour
frame_update  out  1  one-cycle pulse on each frame-update cycle

Behaviour:
- Reset (async assert, sync release): hcount=0, vcount=0; hsync=1, vsync=1, de=0, rgb=0, frame_update=0. All staging heights, active heights and peaks are 0; commit_pending=0.
- Counters: hcount runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800 at defaults). vcount increments when hcount wraps and runs 0..V_TOTAL-1 (525 at defaults). Both wrap to 0.
- Raw sync: hsync_raw is low for H_DISPLAY+H_FRONT <= hcount < H_DISPLAY+H_FRONT+H_SYNC. vsync_raw uses the same window on vcount. de_raw = hcount<H_DISPLAY && vcount<V_DISPLAY.
- Write path: on bin_valid, the height is computed and stored in staging[bin_idx].
  - Height is 0 if bin_data is negative (MSB set); otherwise min(bin_data>>SCALE_SHIFT, V_DISPLAY).
  - bin_idx >= NUM_BARS: write ignored.
  - Repeated writes to the same index: last write wins.
- bin_commit sets commit_pending.
- Update cycle: hcount==0 && vcount==V_DISPLAY (first vblank line).
  - If commit_pending: active <= staging, then commit_pending clears.
  - Every update cycle, for each bar: peak <= max(new_active, sat0(peak - PEAK_DECAY)). new_active is the post-copy value.
  - frame_update pulses on this cycle, registered, so it is visible one clock later.
- Collisions on the update cycle:
  - A bin_valid write lands in staging after the copy and is not shown this frame.
  - A bin_commit re-arms commit_pending for the next frame.
- Pixel pipeline: column tracking uses bar_x (0..BAR_W-1) and bar_idx counters cleared at hcount==0. No divider is used.
  - Stage 1 registers the active height, peak and gap flag for bar_idx, plus the row y=vcount.
  - Stage 2 computes colour.
  - hsync, vsync and de are delayed to match. All outputs reflect the counter state 2 clocks earlier, which is fixed latency.
- Colour rules in stage 2, in priority order:
  - Not de: 000.
  - Gap (bar_x >= BAR_W-BAR_GAP): 000.
  - Peak marker (peak>0 && y == V_DISPLAY-peak): FFF.
  - Lit (y >= V_DISPLAY-height): F00 if y < V_DISPLAY/3; FF0 if y < 2*V_DISPLAY/3; 0F0 otherwise.
  - Anything else: 000.
- Reset mid-frame: everything returns to reset values immediately. Scanning restarts at (0,0) and no commit is retained.

Test Plan:
- Reset and timing (defaults) -> hsync low exactly 96 clocks per 800-clock line; vsync low exactly 2 lines (1600 clocks); frame = 420000 clocks; de high 640 clocks on each of lines 0..479; frame_update once per frame.
- Write idx 3, data 0x001000, commit, then wait one update -> height 64; on each line, pixels 120..157 are lit for rows 416..479 and 158..159 are black. Row 416 shows FFF (peak). Rows 417..479 are 0F0 because they are below row 320. Latency is 2 clocks from counters.
- Clamping: data 0x800010 -> bar dark; data 0x7FFFFF -> height 480, full-height bar with red rows 0..159, yellow 160..319, green 320..479, and the peak marker at row 0.
- Peak decay: height 200 committed, then 0 committed -> marker at row 280, then 284, 288, ... one step per frame until the peak reaches 0 and the marker disappears; bar body vanishes on the first zero frame.
- Write without commit -> display unchanged across 3 frames. Write plus commit asserted exactly on the update cycle -> change appears only after the following update.
- Assert rst_n low mid-line at hcount=300, vcount=200 -> outputs go to reset values asynchronously; after release, the first hsync low starts at clock 656+2.
